mem_copy_dma: RTL

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 93 +++++++++
 1 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: word-by-word RAM-to-RAM copy engine with a range check.
// Ports: clk/rst (sync, active-high); i_start, i_src_addr, i_dst_addr, i_length request a copy;
// o_busy, o_done, o_error, o_words_done report status;
// o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata, i_mem_rdata form the RAM port.
module mem_copy_dma #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_src_addr,
    input  logic [31:0] i_dst_addr,
    input  logic [8:0]  i_length,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [8:0]  o_words_done,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;
    logic [2:0]  r_state, w_next;
    logic [31:0] r_src, r_dst, r_mem_addr, r_buf;
    logic [8:0]  r_len, r_idx, r_words, w_idx_inc;
    logic        r_error, r_mem_read, r_mem_write, w_bad;
    assign w_idx_inc = r_idx + 9'd1;
    // 33-bit sums so an end address past 2^32 cannot wrap back into range
    assign w_bad = ({1'b0, r_src} + {24'b0, r_len} > 33'(DEPTH)) ||
                   ({1'b0, r_dst} + {24'b0, r_len} > 33'(DEPTH));
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = i_start ? CHECK : IDLE;
            CHECK:   w_next = w_bad ? IDLE : (r_len == 9'd0 ? FIN : READ);
            READ:    w_next = WRITE;
            WRITE:   w_next = (w_idx_inc == r_len) ? FIN : READ;
            default: w_next = IDLE;
        endcase
    end
    // strobes and address are registered from the next state so they are stable for the whole cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_words     <= '0;
            r_buf       <= '0;
            r_mem_addr  <= '0;
            r_error     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_error     <= (r_state == CHECK) && w_bad;
            r_mem_read  <= (w_next == READ);
            r_mem_write <= (w_next == WRITE);
            if (r_state == IDLE && i_start) begin
                r_src   <= i_src_addr;
                r_dst   <= i_dst_addr;
                r_len   <= i_length;
                r_idx   <= '0;
                r_words <= '0;
            end
            if (w_next == READ)
                r_mem_addr <= r_src + 32'(r_state == WRITE ? w_idx_inc : r_idx);
            if (w_next == WRITE)
                r_mem_addr <= r_dst + 32'(r_idx);
            if (r_state == READ)
                r_buf <= i_mem_rdata;
            if (r_state == WRITE) begin
                r_idx   <= w_idx_inc;
                r_words <= r_words + 9'd1;
            end
        end
    end
    assign o_busy       = (r_state == CHECK) || (r_state == READ) || (r_state == WRITE);
    assign o_done       = (r_state == FIN);
    assign o_error      = r_error;
    assign o_words_done = r_words;
    assign o_mem_read   = r_mem_read;
    assign o_mem_write  = r_mem_write;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_buf;
endmodule
